// File: rtl/vga_timing_ctrl.sv
// VGA raster timing master: drives pixel coordinates to the renderer and
// delay-matches HS/VS/BLANK so they reach the DAC on the same clock as the RGB.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned SYNC_NEG = 1
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic [9:0] oVGA_R,
    output logic [9:0] oVGA_G,
    output logic [9:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_n,
    output logic       oFrame_tick
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SBEG  = H_ACTIVE + H_FP;
    localparam int unsigned H_SEND  = H_SBEG + H_SYNC;
    localparam int unsigned V_SBEG  = V_ACTIVE + V_FP;
    localparam int unsigned V_SEND  = V_SBEG + V_SYNC;

    localparam logic [CNT_W-1:0] hLast    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] vLast    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] hActEnd  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] vActEnd  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] hSyncBeg = CNT_W'(H_SBEG);
    localparam logic [CNT_W-1:0] hSyncEnd = CNT_W'(H_SEND);
    localparam logic [CNT_W-1:0] vSyncBeg = CNT_W'(V_SBEG);
    localparam logic [CNT_W-1:0] vSyncEnd = CNT_W'(V_SEND);
    localparam logic             syncInv  = 1'(SYNC_NEG);

    logic [CNT_W-1:0] hCnt;
    logic [CNT_W-1:0] vCnt;
    logic             hWrap;
    logic             rawAct;
    logic             rawHs;
    logic             rawVs;
    logic             frameStart;

    logic             actS0;
    logic             hsS0;
    logic             vsS0;
    logic [PIX_LAT-1:0] actPipe;
    logic [PIX_LAT-1:0] hsPipe;
    logic [PIX_LAT-1:0] vsPipe;
    logic             actDly;
    logic             hsDly;
    logic             vsDly;

    // Raster decode from the free-running counters
    always_comb begin
        hWrap      = (hCnt == hLast);
        rawAct     = (hCnt < hActEnd) && (vCnt < vActEnd);
        rawHs      = (hCnt >= hSyncBeg) && (hCnt < hSyncEnd);
        rawVs      = (vCnt >= vSyncBeg) && (vCnt < vSyncEnd);
        frameStart = (hCnt == '0) && (vCnt == vActEnd);
    end

    // Horizontal / vertical counters; v advances only on the h wrap
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hWrap) begin
            hCnt <= '0;
            vCnt <= (vCnt == vLast) ? '0 : vCnt + CNT_W'(1);
        end else begin
            hCnt <= hCnt + CNT_W'(1);
        end
    end

    // Coordinate request bus and undelayed frame tick
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oVGA_X      <= '0;
            oVGA_Y      <= '0;
            oFrame_tick <= 1'b0;
        end else begin
            oVGA_X      <= rawAct ? hCnt : '0;
            oVGA_Y      <= rawAct ? vCnt : '0;
            oFrame_tick <= frameStart;
        end
    end

    // Stage 0 capture plus PIX_LAT-deep shift to match renderer latency
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            actS0   <= 1'b0;
            hsS0    <= 1'b0;
            vsS0    <= 1'b0;
            actPipe <= '0;
            hsPipe  <= '0;
            vsPipe  <= '0;
        end else begin
            actS0      <= rawAct;
            hsS0       <= rawHs;
            vsS0       <= rawVs;
            actPipe[0] <= actS0;
            hsPipe[0]  <= hsS0;
            vsPipe[0]  <= vsS0;
            for (int i = 1; i < int'(PIX_LAT); i++) begin
                actPipe[i] <= actPipe[i-1];
                hsPipe[i]  <= hsPipe[i-1];
                vsPipe[i]  <= vsPipe[i-1];
            end
        end
    end

    always_comb begin
        actDly = actPipe[PIX_LAT-1];
        hsDly  = hsPipe[PIX_LAT-1];
        vsDly  = vsPipe[PIX_LAT-1];
    end

    // DAC output register; blanking forces colour to black
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_BLANK_n <= 1'b0;
            oVGA_HS      <= syncInv;
            oVGA_VS      <= syncInv;
        end else begin
            oVGA_R       <= actDly ? iRed   : COL_W'(0);
            oVGA_G       <= actDly ? iGreen : COL_W'(0);
            oVGA_B       <= actDly ? iBlue  : COL_W'(0);
            oVGA_BLANK_n <= actDly;
            oVGA_HS      <= hsDly ^ syncInv;
            oVGA_VS      <= vsDly ^ syncInv;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two instances (latency 1 and 3, both sync polarities)
// on a shrunken raster, compared each clock against an arithmetic raster model.
module tb_vga_timing_ctrl;

    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 3;
    localparam int unsigned HSW = 5;
    localparam int unsigned HBP = 4;
    localparam int unsigned VA  = 5;
    localparam int unsigned VFP = 2;
    localparam int unsigned VSW = 2;
    localparam int unsigned VBP = 3;
    localparam int unsigned HT  = HA + HFP + HSW + HBP;
    localparam int unsigned VT  = VA + VFP + VSW + VBP;
    localparam int unsigned FT  = HT * VT;

    logic clk;
    logic rstN;

    logic [9:0] blueMem [HA*VA];

    logic [9:0] x1, y1, r1, g1, b1;
    logic       hs1, vs1, bl1, tk1;
    logic [9:0] red1, blue1;

    logic [9:0] x3, y3, r3, g3, b3;
    logic       hs3, vs3, bl3, tk3;
    logic [9:0] redP3  [3];
    logic [9:0] blueP3 [3];

    int unsigned vecCnt;
    int unsigned errCnt;
    int unsigned edgeCnt;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIX_LAT(1), .SYNC_NEG(1)
    ) u_dut1 (
        .iVGA_CLK(clk), .iRST_n(rstN),
        .iRed(red1), .iGreen(10'h3FF), .iBlue(blue1),
        .oVGA_X(x1), .oVGA_Y(y1),
        .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
        .oVGA_HS(hs1), .oVGA_VS(vs1), .oVGA_BLANK_n(bl1),
        .oFrame_tick(tk1)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .PIX_LAT(3), .SYNC_NEG(0)
    ) u_dut3 (
        .iVGA_CLK(clk), .iRST_n(rstN),
        .iRed(redP3[2]), .iGreen(10'h3FF), .iBlue(blueP3[2]),
        .oVGA_X(x3), .oVGA_Y(y3),
        .oVGA_R(r3), .oVGA_G(g3), .oVGA_B(b3),
        .oVGA_HS(hs3), .oVGA_VS(vs3), .oVGA_BLANK_n(bl3),
        .oFrame_tick(tk3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] lookBlue(input logic [9:0] x, input logic [9:0] y);
        int unsigned idx;
        idx = int'(y) * HA + int'(x);
        return (idx < HA * VA) ? blueMem[idx] : 10'h0;
    endfunction

    // Bench renderers: red = column, green constant white, blue random per pixel
    always @(posedge clk) begin
        red1      <= x1;
        blue1     <= lookBlue(x1, y1);
        redP3[0]  <= x3;
        blueP3[0] <= lookBlue(x3, y3);
        for (int i = 1; i < 3; i++) begin
            redP3[i]  <= redP3[i-1];
            blueP3[i] <= blueP3[i-1];
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", tag, $time, edgeCnt, obs, exp);
        end
    endtask

    // Expected pins after e clock edges since reset release (e=0 means in reset)
    task automatic checkDut(input string nm, input int unsigned e, input int unsigned lat,
                            input bit neg,
                            input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                            input logic hs, input logic vs, input logic bl, input logic tk);
        int unsigned p, h, v, lt;
        bit vis, hsOn, vsOn, tick;
        logic [9:0] ex, ey, er, eg, eb;
        ex = '0; ey = '0; tick = 1'b0;
        if (e >= 1) begin
            p = (e - 1) % FT;
            h = p % HT;
            v = p / HT;
            if (h < HA && v < VA) begin
                ex = 10'(h);
                ey = 10'(v);
            end
            tick = (p == VA * HT);
        end
        lt = lat + 2;
        vis = 1'b0; hsOn = 1'b0; vsOn = 1'b0;
        er = '0; eg = '0; eb = '0;
        if (e >= lt) begin
            p = (e - lt) % FT;
            h = p % HT;
            v = p / HT;
            vis  = (h < HA) && (v < VA);
            hsOn = (h >= HA + HFP) && (h < HA + HFP + HSW);
            vsOn = (v >= VA + VFP) && (v < VA + VFP + VSW);
            if (vis) begin
                er = 10'(h);
                eg = 10'h3FF;
                eb = blueMem[v * HA + h];
            end
        end
        checkVal({nm, ".X"},     32'(x),  32'(ex));
        checkVal({nm, ".Y"},     32'(y),  32'(ey));
        checkVal({nm, ".R"},     32'(r),  32'(er));
        checkVal({nm, ".G"},     32'(g),  32'(eg));
        checkVal({nm, ".B"},     32'(b),  32'(eb));
        checkVal({nm, ".BLANK"}, 32'(bl), 32'(vis));
        checkVal({nm, ".HS"},    32'(hs), 32'(hsOn ^ neg));
        checkVal({nm, ".VS"},    32'(vs), 32'(vsOn ^ neg));
        checkVal({nm, ".TICK"},  32'(tk), 32'(tick));
    endtask

    task automatic checkAll(input int unsigned e);
        checkDut("lat1", e, 1, 1'b1, x1, y1, r1, g1, b1, hs1, vs1, bl1, tk1);
        checkDut("lat3", e, 3, 1'b0, x3, y3, r3, g3, b3, hs3, vs3, bl3, tk3);
    endtask

    task automatic runCycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            edgeCnt++;
            @(negedge clk);
            checkAll(edgeCnt);
        end
    endtask

    task automatic holdReset(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            checkAll(0);
        end
    endtask

    task automatic releaseReset;
        rstN    = 1'b1;
        edgeCnt = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic midReset;
        #2;
        rstN = 1'b0;
        #1;
        checkAll(0);
        holdReset(3);
        releaseReset();
    endtask

    initial begin
        vecCnt  = 0;
        errCnt  = 0;
        edgeCnt = 0;
        rstN    = 1'b0;
        for (int i = 0; i < int'(HA * VA); i++) blueMem[i] = 10'($urandom);

        holdReset(10);
        releaseReset();
        runCycles(3 * FT + 20);

        for (int k = 0; k < 3; k++) begin
            midReset();
            runCycles($urandom_range(30, FT + 60));
        end

        midReset();
        runCycles(FT + 40);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
